seq_mul_280: RTL and testbench

Sequential carry-less (GF(2)[x]) multiplier for 1120-bit polynomial operands supplied as four 280-bit limbs per operand. It produces a 2240-bit product by iterating one 280×280 carry-less limb product per clock and accumulating by XOR. It is the core arithmetic unit of the large-polynomial multiplication datapath and is started by releasing reset.

---
 rtl/seq_mul_280_pkg.sv | 17 +
 rtl/seq_mul_280_clmul.sv | 18 +
 rtl/seq_mul_280.sv | 91 +++++++++
 tb/tb_seq_mul_280.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/seq_mul_280_pkg.sv
// Shared constants and FSM state type for the 1120-bit carry-less multiplier.
// Latency and backpressure are properties of the top level; this file holds no logic.
package seq_mul_280_pkg;

  localparam int LIMB_W = 280;
  localparam int NLIMB  = 4;
  localparam int OP_W   = LIMB_W * NLIMB;
  localparam int RES_W  = 2 * OP_W;
  localparam int PROD_W = 2 * LIMB_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_280_clmul.sv
// 280x280 carry-less limb multiplier: XOR of shifted partial products, 559-bit result.
// Purely combinational (zero latency); no flow control.
module clmul_280
  import seq_mul_280_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int n = 0; n < LIMB_W; n++) begin
      if (b[n]) p = p ^ (PROD_W'(a) << n);
    end
  end

endmodule

// File: rtl/seq_mul_280.sv
// Sequential GF(2)[x] 1120x1120 multiplier; one limb product per clock, W valid 18 edges after reset release.
// No backpressure: runs once per reset release and holds W/done until the next reset.
module seq_mul_280
  import seq_mul_280_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LIMB_W-1:0] U0,
  input  logic [LIMB_W-1:0] U1,
  input  logic [LIMB_W-1:0] U2,
  input  logic [LIMB_W-1:0] U3,
  input  logic [LIMB_W-1:0] V0,
  input  logic [LIMB_W-1:0] V1,
  input  logic [LIMB_W-1:0] V2,
  input  logic [LIMB_W-1:0] V3,
  output logic [RES_W-1:0]  W,
  output logic              done
);

  state_t            state_q, state_d;
  logic [3:0]        k_q;
  logic [LIMB_W-1:0] u_q [NLIMB];
  logic [LIMB_W-1:0] v_q [NLIMB];
  logic [RES_W-2:0]  acc_q;

  logic [1:0]        i_idx, j_idx;
  logic [PROD_W-1:0] prod;
  logic [10:0]       off;
  logic [RES_W-2:0]  prod_sh;

  assign i_idx = k_q[3:2];
  assign j_idx = k_q[1:0];

  // Index 0 is the most-significant limb, so limb i sits at 280*(3-i).
  clmul_280 u_clmul (
    .a (u_q[i_idx]),
    .b (v_q[j_idx]),
    .p (prod)
  );

  always_comb begin
    off     = 11'(LIMB_W * (2 * (NLIMB - 1) - int'(i_idx) - int'(j_idx)));
    prod_sh = (RES_W - 1)'(prod) << off;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (k_q == 4'd15) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q   <= '0;
      acc_q <= '0;
      u_q   <= '{default: '0};
      v_q   <= '{default: '0};
      W     <= '0;
      done  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          u_q   <= '{U0, U1, U2, U3};
          v_q   <= '{V0, V1, V2, V3};
          acc_q <= '0;
          k_q   <= '0;
        end
        RUN: begin
          acc_q <= acc_q ^ prod_sh;
          k_q   <= k_q + 4'd1;
        end
        DONE: begin
          // W is only loaded once the accumulator is complete, so partial sums never leak out.
          W    <= {acc_q, 1'b0};
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_280.sv
// Randomized self-checking bench for seq_mul_280 against a full-width bit-level clmul model.
module tb_seq_mul_280;

  localparam int LW = 280;
  localparam int OW = 1120;
  localparam int RW = 2240;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [LW-1:0] U0 = '0, U1 = '0, U2 = '0, U3 = '0;
  logic [LW-1:0] V0 = '0, V1 = '0, V2 = '0, V3 = '0;
  logic [RW-1:0] W;
  logic          done;

  int errs   = 0;
  int checks = 0;

  seq_mul_280 dut (
    .clk   (clk),
    .reset (reset),
    .U0    (U0), .U1 (U1), .U2 (U2), .U3 (U3),
    .V0    (V0), .V1 (V1), .V2 (V2), .V3 (V3),
    .W     (W),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    int first;
    checks++;
    if (got !== exp) begin
      errs++;
      first = -1;
      for (int n = 0; n < RW; n++) begin
        if (first < 0 && got[n] !== exp[n]) first = n;
      end
      $display("FAIL %s: got[63:0]=%h exp[63:0]=%h first_diff_bit=%0d got_bit=%b exp_bit=%b",
               tag, got[63:0], exp[63:0], first, got[first], exp[first]);
    end
  endtask

  // W[p+q+1] ^= A[p] & B[q], computed over the whole 1120-bit operands.
  function automatic logic [RW-1:0] ref_mul(input logic [OW-1:0] a, input logic [OW-1:0] b);
    logic [RW-1:0] w;
    w = '0;
    for (int p = 0; p < OW; p++) begin
      if (a[p]) w = w ^ ({{OW{1'b0}}, b} << (p + 1));
    end
    return w;
  endfunction

  function automatic logic [OW-1:0] rand_op();
    logic [OW-1:0] r;
    r = '0;
    for (int n = 0; n < OW / 32; n++) r[n*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_ops(input logic [OW-1:0] a, input logic [OW-1:0] b);
    {U0, U1, U2, U3} = a;
    {V0, V1, V2, V3} = b;
  endtask

  // Reset pulse with operands applied; the next posedge after return is edge 1.
  task automatic start(input logic [OW-1:0] a, input logic [OW-1:0] b);
    @(negedge clk);
    reset = 1'b0;
    set_ops(a, b);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_check(input string tag, input logic [OW-1:0] a, input logic [OW-1:0] b,
                           input logic [RW-1:0] exp);
    start(a, b);
    repeat (17) @(posedge clk);
    #1;
    check({tag, "_done_e17"}, RW'(done), RW'(1'b0));
    check({tag, "_w_e17"}, W, '0);
    @(posedge clk);
    #1;
    check({tag, "_done_e18"}, RW'(done), RW'(1'b1));
    check(tag, W, exp);
  endtask

  initial begin
    logic [OW-1:0] a, b;
    logic [RW-1:0] exp;

    #12;
    check("reset_w", W, '0);
    check("reset_done", RW'(done), RW'(1'b0));

    a = '0; a[0] = 1'b1;
    b = '0; b[0] = 1'b1;
    exp = '0; exp[1] = 1'b1;
    run_check("unit", a, b, exp);

    run_check("zero_a", '0, rand_op(), '0);
    run_check("zero_b", rand_op(), '0, '0);

    a = '0; a[840] = 1'b1;
    b = '0; b[840] = 1'b1;
    exp = '0; exp[1681] = 1'b1;
    run_check("cross_limb", a, b, exp);

    a = {280'(842834), 280'(149214), 280'(813413), 280'(9945245)};
    b = {280'(8814232), 280'(8842834), 280'(9148123), 280'(14283424)};
    run_check("fixed_vec", a, b, ref_mul(a, b));

    for (int t = 0; t < 100; t++) begin
      a = rand_op();
      b = rand_op();
      run_check($sformatf("rand_%0d", t), a, b, ref_mul(a, b));
    end

    // Abort at RUN step 8, then restart with fresh operands.
    start(rand_op(), rand_op());
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_done", RW'(done), RW'(1'b0));
    check("abort_w", W, '0);
    a = rand_op();
    b = rand_op();
    exp = ref_mul(a, b);
    run_check("after_abort", a, b, exp);

    // Inputs changing after completion must not disturb the held result.
    set_ops(rand_op(), rand_op());
    repeat (5) @(posedge clk);
    #1;
    check("hold_w", W, exp);
    check("hold_done", RW'(done), RW'(1'b1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
